// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional counters are enabled with the FETCH_PERF_EN macro (see fetch_unit).
package fetch_pkg;

    localparam int unsigned PC_STEP = 4;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    // Queue entries carry a PC_W-wide pc; fetch_unit casts to/from XLEN.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} pairs; slot0 is always the head.
// Flush empties the queue; stale slot contents are left in place.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output logic         head_valid_o,
    output fetch_entry_t head_o
);

    fetch_entry_t slot0_q, slot0_d;
    fetch_entry_t slot1_q, slot1_d;
    logic [1:0]   count_q, count_d;
    logic         pop;

    assign pop = pop_i && (count_q != 2'd0);

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            unique case ({push_i, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        slot0_d = push_entry_i;
                    end else begin
                        slot1_d = push_entry_i;
                    end
                    if (count_q != 2'd2) begin
                        count_d = sat_inc2(count_q);
                    end
                end
                2'b01: begin
                    slot0_d = slot1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new entry lands behind the survivor.
                    if (count_q == 2'd1) begin
                        slot0_d = push_entry_i;
                    end else begin
                        slot0_d = slot1_q;
                        slot1_d = push_entry_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != 2'd0);
    assign head_o       = slot0_q;

`ifndef SYNTHESIS
    overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !pop && !flush_i && count_q == 2'd2))
        else $error("fetch_queue: push into full queue");
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one word read at a time and buffers
// responses in a 2-entry queue. Define FETCH_PERF_EN to add perf_fetched/perf_dropped.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [XLEN-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_dropped
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] addr_q;
    logic            outstanding_q, outstanding_d;

    logic            pop, grant, rsp_live, push, discard;
    logic [1:0]      q_count;
    logic [2:0]      occupancy;
    fetch_entry_t    push_entry, head;

    assign pop      = if_valid && !stall;
    assign grant    = imem_req && imem_gnt;
    assign rsp_live = imem_rvalid && outstanding_q;
    assign push     = rsp_live && (state_q == FETCH) && !redirect_valid;
    assign discard  = rsp_live && (redirect_valid || state_q == DROP);

    // Entries held plus the one in flight, after this cycle's pop.
    assign occupancy = 3'(q_count) + 3'(outstanding_q) - 3'(pop);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (redirect_valid && outstanding_q && !imem_rvalid) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    state_d = (outstanding_q && !imem_rvalid) ? DROP : FETCH;
                end else if (imem_rvalid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs toward instruction memory.
    always_comb begin
        imem_req = 1'b0;
        if ((state_q == FETCH) && !redirect_valid && (!outstanding_q || imem_rvalid) &&
            (occupancy < 3'd2)) begin
            imem_req = 1'b1;
        end
        imem_addr = imem_req ? pc_q : addr_q;
    end

    always_comb begin
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        if (grant) begin
            outstanding_d = 1'b1;
            req_pc_d      = pc_q;
            pc_d          = pc_q + XLEN'(PC_STEP);
        end else if (imem_rvalid) begin
            outstanding_d = 1'b0;
        end
        if (redirect_valid) begin
            pc_d = redirect_pc & ~XLEN'(3);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            addr_q        <= '0;
            outstanding_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            addr_q        <= imem_addr;
            outstanding_q <= outstanding_d;
        end
    end

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = PC_W'(req_pc_q);
        push_entry.instr = imem_rdata;
    end

    fetch_queue u_queue (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (push),
        .push_entry_i(push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .count_o     (q_count),
        .head_valid_o(if_valid),
        .head_o      (head)
    );

    assign if_pc    = XLEN'(head.pc);
    assign if_instr = head.instr;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_dropped_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            if (push && perf_fetched_q != '1) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (discard && perf_dropped_q != '1) begin
                perf_dropped_q <= perf_dropped_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`else
    logic unused_discard;
    assign unused_discard = discard;
`endif

`ifndef SYNTHESIS
    stray_rvalid_a: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && !outstanding_q && state_q == FETCH))
        else $warning("fetch_unit: rvalid with nothing outstanding ignored");
`endif

endmodule
